// File: rtl/axi_mem_pkg.sv
// Shared constants and state encodings for the AXI-Lite memory model.
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [2:0] {
    WR_IDLE = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_WAIT = 3'd3,
    WR_RESP = 3'd4
  } wr_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR, shifts left one step per enabled cycle; TAPS selects feedback bits.
module lfsr_gen #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= SEED;
    end else if (en) begin
      value <= {value[WIDTH-2:0], ^(value & TAPS)};
    end
  end

endmodule

// File: rtl/axi_lite_mem_model.sv
// AXI-Lite slave memory with fixed or pseudo-random response latency.
//
// state   | meaning
// RD_IDLE | waiting for AR handshake
// RD_WAIT | counting down read latency
// RD_RESP | rdata/rresp valid, waiting for rready
// WR_IDLE | waiting for AW and/or W
// WR_ADDR | W captured, waiting for AW
// WR_DATA | AW captured, waiting for W
// WR_WAIT | write committed, counting down latency
// WR_RESP | bresp valid, waiting for bready
module axi_lite_mem_model
  import axi_mem_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE      = 32'h8000_0000,
  parameter int                LAT_MODE  = 0,
  parameter int                FIXED_LAT = 1,
  parameter int                RAND_MAX  = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wmask,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int NB      = DATA_W / 8;
  localparam int OFF_W   = $clog2(NB);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int LAT_MAX = max_int(max_int(FIXED_LAT, RAND_MAX), 1);
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam int LFSR_W  = 16;
  localparam logic [LFSR_W-1:0] RAND_MASK = LFSR_W'(RAND_MAX);

  rd_state_t         rd_state;
  wr_state_t         wr_state;
  logic [ADDR_W-1:0] ar_q, aw_q;
  logic [DATA_W-1:0] w_q;
  logic [NB-1:0]     m_q;
  logic [CNT_W-1:0]  rd_cnt, wr_cnt, rd_lat, wr_lat;
  logic [LFSR_W-1:0] rd_lfsr, wr_lfsr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ar_hs, rd_ok, wr_commit, wr_ok;
  logic [ADDR_W-1:0] rd_addr, rd_word, c_addr, wr_word;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [DATA_W-1:0] rd_sample, c_data;
  logic [NB-1:0]     c_mask;

  // While idle the read path looks at the live bus so a zero-latency read can sample immediately.
  assign ar_hs     = arvalid && (rd_state == RD_IDLE);
  assign rd_addr   = (rd_state == RD_IDLE) ? araddr : ar_q;
  assign rd_word   = (rd_addr - BASE) >> OFF_W;
  assign rd_ok     = (rd_addr >= BASE) && (rd_word < ADDR_W'(DEPTH));
  assign rd_idx    = rd_word[IDX_W-1:0];
  assign rd_sample = rd_ok ? mem[rd_idx] : '0;

  always_comb begin
    wr_commit = 1'b0;
    case (wr_state)
      WR_IDLE: wr_commit = awvalid && wvalid;
      WR_ADDR: wr_commit = awvalid;
      WR_DATA: wr_commit = wvalid;
      default: wr_commit = 1'b0;
    endcase
  end

  assign c_addr  = (wr_state == WR_DATA) ? aw_q : awaddr;
  assign c_data  = (wr_state == WR_ADDR) ? w_q : wdata;
  assign c_mask  = (wr_state == WR_ADDR) ? m_q : wmask;
  assign wr_word = (c_addr - BASE) >> OFF_W;
  assign wr_ok   = (c_addr >= BASE) && (wr_word < ADDR_W'(DEPTH));
  assign wr_idx  = wr_word[IDX_W-1:0];

  assign rd_lat = (LAT_MODE != 0) ? CNT_W'(rd_lfsr & RAND_MASK) : CNT_W'(FIXED_LAT);
  assign wr_lat = (LAT_MODE != 0) ? CNT_W'(wr_lfsr & RAND_MASK) : CNT_W'(FIXED_LAT);

  lfsr_gen #(.WIDTH(LFSR_W), .TAPS(16'hB400), .SEED(16'hACE1)) u_rd_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (ar_hs),
    .value (rd_lfsr)
  );

  lfsr_gen #(.WIDTH(LFSR_W), .TAPS(16'hD008), .SEED(16'h1D0F)) u_wr_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (wr_commit),
    .value (wr_lfsr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      ar_q     <= '0;
      rd_cnt   <= '0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (arvalid) begin
            ar_q <= araddr;
            if (rd_lat == '0) begin
              rd_state <= RD_RESP;
              rdata    <= rd_sample;
              rresp    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
              rd_cnt   <= rd_lat - CNT_W'(1);
              rd_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (rd_cnt == '0) begin
            rd_state <= RD_RESP;
            rdata    <= rd_sample;
            rresp    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            rd_cnt <= rd_cnt - CNT_W'(1);
          end
        end
        RD_RESP: if (rready) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      aw_q     <= '0;
      w_q      <= '0;
      m_q      <= '0;
      wr_cnt   <= '0;
      bresp    <= RESP_OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (awvalid && !wvalid) begin
            aw_q     <= awaddr;
            wr_state <= WR_DATA;
          end else if (wvalid && !awvalid) begin
            w_q      <= wdata;
            m_q      <= wmask;
            wr_state <= WR_ADDR;
          end
        end
        WR_ADDR, WR_DATA: ;
        WR_WAIT: begin
          if (wr_cnt == '0) wr_state <= WR_RESP;
          else              wr_cnt   <= wr_cnt - CNT_W'(1);
        end
        WR_RESP: if (bready) wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
      // Completing handshake overrides the per-state moves above.
      if (wr_commit) begin
        bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_lat == '0) begin
          wr_state <= WR_RESP;
        end else begin
          wr_cnt   <= wr_lat - CNT_W'(1);
          wr_state <= WR_WAIT;
        end
      end
    end
  end

  // Memory is never reset; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_commit && wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (c_mask[b]) mem[wr_idx][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  assign arready = (rd_state == RD_IDLE);
  assign rvalid  = (rd_state == RD_RESP);
  assign awready = (wr_state == WR_IDLE) || (wr_state == WR_ADDR);
  assign wready  = (wr_state == WR_IDLE) || (wr_state == WR_DATA);
  assign bvalid  = (wr_state == WR_RESP);

endmodule

// File: tb/tb_axi_lite_mem_model.sv
// Directed bench: vector table on a fixed-latency instance plus split-write,
// collision, random-latency and mid-transaction reset sequences.
module tb_axi_lite_mem_model;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic [3:0]  wmask = '0;
  logic [1:0]  rresp, bresp;

  logic [31:0] r2_araddr = '0, r2_awaddr = '0, r2_wdata = '0, r2_rdata;
  logic        r2_arvalid = 1'b0, r2_arready, r2_rvalid, r2_rready = 1'b0;
  logic        r2_awvalid = 1'b0, r2_awready, r2_wvalid = 1'b0, r2_wready, r2_bvalid, r2_bready = 1'b0;
  logic [3:0]  r2_wmask = 4'hF;
  logic [1:0]  r2_rresp, r2_bresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_mem_model #(.LAT_MODE(0), .FIXED_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wmask(wmask), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_lite_mem_model #(.LAT_MODE(1), .RAND_MAX(7)) u_rnd (
    .clk(clk), .reset(reset),
    .araddr(r2_araddr), .arvalid(r2_arvalid), .arready(r2_arready),
    .rdata(r2_rdata), .rresp(r2_rresp), .rvalid(r2_rvalid), .rready(r2_rready),
    .awaddr(r2_awaddr), .awvalid(r2_awvalid), .awready(r2_awready),
    .wdata(r2_wdata), .wmask(r2_wmask), .wvalid(r2_wvalid), .wready(r2_wready),
    .bresp(r2_bresp), .bvalid(r2_bvalid), .bready(r2_bready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    bit          wr;
    bit          rd;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          output logic [1:0] resp, output int n);
    bit got;
    got = 0;
    n = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wmask = m; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      n++;
      if (bvalid) begin got = 1; break; end
    end
    resp = got ? bresp : 2'b11;
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int n);
    bit got;
    got = 0;
    n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      arvalid = 1'b0;
      n++;
      if (rvalid) begin got = 1; break; end
    end
    d    = got ? rdata : 32'hXXXX_XXXX;
    resp = got ? rresp : 2'b11;
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  resp;
    int          n;
    logic [7:0]  lat_seen;
    bit          got;

    vecs[0]  = '{32'h8000_0000, 32'h0102_0304, 4'hF, 1'b1, 1'b1, 2'b00, 32'h0102_0304};
    vecs[1]  = '{32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 2'b00, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h8000_0020, 32'h1122_3344, 4'hF, 1'b1, 1'b1, 2'b00, 32'h1122_3344};
    vecs[3]  = '{32'h8000_0020, 32'h0000_AA00, 4'h2, 1'b1, 1'b1, 2'b00, 32'h1122_AA44};
    vecs[4]  = '{32'h8000_0023, 32'h5500_0000, 4'h8, 1'b1, 1'b1, 2'b00, 32'h5522_AA44};
    vecs[5]  = '{32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b1, 2'b00, 32'hCAFE_F00D};
    vecs[6]  = '{32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 2'b10, 32'h0000_0000};
    vecs[7]  = '{32'h7FFF_FFFC, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 2'b10, 32'h0000_0000};
    vecs[8]  = '{32'h8000_0000, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 2'b00, 32'h0102_0304};
    vecs[9]  = '{32'h8000_0010, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 2'b00, 32'hDEAD_BEEF};
    vecs[10] = '{32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b1, 2'b00, 32'hDEAD_BEEF};

    repeat (3) @(negedge clk);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready",  32'(wready),  32'd1);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_resps",   32'({rresp, bresp}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wmask, resp, n);
        check($sformatf("v%0d_bresp", i), 32'(resp), 32'(vecs[i].resp));
        check($sformatf("v%0d_wlat", i), 32'(n), 32'd2);
      end
      if (vecs[i].rd) begin
        do_read(vecs[i].addr, d, resp, n);
        check($sformatf("v%0d_rdata", i), d, vecs[i].rdata);
        check($sformatf("v%0d_rresp", i), 32'(resp), 32'(vecs[i].resp));
        check($sformatf("v%0d_rlat", i), 32'(n), 32'd2);
      end
    end

    // Split write: AW first, W three cycles later; a read sampling on the commit edge sees old data.
    do_write(32'h8000_0030, 32'h1357_9BDF, 4'hF, resp, n);
    @(negedge clk);
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("split_awready_c1", 32'(awready), 32'd0);
    check("split_wready_c1",  32'(wready),  32'd1);
    @(negedge clk);
    check("split_awready_c2", 32'(awready), 32'd0);
    araddr = 32'h8000_0030; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    check("split_awready_c3", 32'(awready), 32'd0);
    wdata = 32'h0BAD_CAFE; wmask = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("collide_rvalid", 32'(rvalid), 32'd1);
    check("collide_rdata",  rdata, 32'h1357_9BDF);
    check("split_bvalid_early", 32'(bvalid), 32'd0);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("split_bvalid", 32'(bvalid), 32'd1);
    check("split_bresp",  32'(bresp),  32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    do_read(32'h8000_0030, d, resp, n);
    check("split_readback", d, 32'h0BAD_CAFE);

    // W before AW
    @(negedge clk);
    wdata = 32'h600D_F00D; wmask = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("wfirst_wready",  32'(wready),  32'd0);
    check("wfirst_awready", 32'(awready), 32'd1);
    @(negedge clk);
    awaddr = 32'h8000_0040; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("wfirst_bvalid_early", 32'(bvalid), 32'd0);
    @(negedge clk);
    check("wfirst_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    do_read(32'h8000_0040, d, resp, n);
    check("wfirst_readback", d, 32'h600D_F00D);

    // Random-latency instance
    @(negedge clk);
    r2_awaddr = 32'h8000_0008; r2_wdata = 32'hA5A5_5A5A; r2_awvalid = 1'b1; r2_wvalid = 1'b1;
    @(posedge clk);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r2_awvalid = 1'b0; r2_wvalid = 1'b0;
      if (r2_bvalid) begin got = 1; break; end
    end
    check("r2_bvalid", 32'(got), 32'd1);
    check("r2_bresp", 32'(r2_bresp), 32'd0);
    r2_bready = 1'b1;
    @(negedge clk);
    r2_bready = 1'b0;

    lat_seen = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      r2_araddr = 32'h8000_0008; r2_arvalid = 1'b1;
      @(posedge clk);
      n = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        r2_arvalid = 1'b0;
        n++;
        if (r2_rvalid) break;
      end
      check("r2_lat_range", 32'(n >= 1 && n <= 8), 32'd1);
      if (n >= 1 && n <= 8) lat_seen[n-1] = 1'b1;
      check("r2_rdata", r2_rdata, 32'hA5A5_5A5A);
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        check("r2_stall_valid", 32'(r2_rvalid), 32'd1);
        check("r2_stall_data", r2_rdata, 32'hA5A5_5A5A);
      end
      r2_rready = 1'b1;
      @(negedge clk);
      r2_rready = 1'b0;
    end
    check("r2_lat_varies", 32'($countones(lat_seen) > 1), 32'd1);

    // Reset while read is in RD_WAIT and write is in WR_DATA; W arrives on the reset edge.
    @(negedge clk);
    araddr = 32'h8000_0010; arvalid = 1'b1;
    awaddr = 32'h8000_0010; awvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0;
    check("mid_awready", 32'(awready), 32'd0);
    check("mid_rvalid",  32'(rvalid),  32'd0);
    reset = 1'b1;
    wdata = 32'hFFFF_FFFF; wmask = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("mrst_arready", 32'(arready), 32'd1);
    check("mrst_awready", 32'(awready), 32'd1);
    check("mrst_wready",  32'(wready),  32'd1);
    check("mrst_rvalid",  32'(rvalid),  32'd0);
    check("mrst_bvalid",  32'(bvalid),  32'd0);
    check("mrst_rdata",   rdata,        32'd0);
    check("mrst_resps",   32'({rresp, bresp}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_rvalid", 32'(rvalid), 32'd0);
      check("post_rst_bvalid", 32'(bvalid), 32'd0);
    end
    do_read(32'h8000_0010, d, resp, n);
    check("post_rst_mem", d, 32'hDEAD_BEEF);
    do_read(32'h8000_0040, d, resp, n);
    check("post_rst_mem2", d, 32'h600D_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
